// File: rtl/dff_pipe_elastic.sv
// dff_pipe_elastic: DEPTH-stage elastic register pipeline with per-stage
// valid bits, valid/ready backpressure, bubble collapse and flush.
// Ports: clk, rst (sync, active-high), flush,
//   in_valid/in_ready/in_data (producer side),
//   out_valid/out_ready/out_data (consumer side), count (valid stages).
module dff_pipe_elastic #(
  parameter int                 WIDTH   = 8,
  parameter int                 DEPTH   = 3,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] uv;
  logic [WIDTH-1:0] ud [DEPTH];
  logic [CNT_W-1:0] cnt_c;

  // A stage can take new data when it, or any stage downstream of it,
  // is empty, or when the consumer drains the last stage. Written as an
  // OR over the downstream valids so there is no recursive net.
  always_comb begin
    rdy = '0;
    rdy[DEPTH] = out_ready;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        rdy[i] = rdy[i] | ~v[j];
      end
    end
  end

  always_comb begin
    uv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ud[i] = in_data;
    end
    uv[0] = in_valid & ~flush;
    for (int i = 1; i < DEPTH; i++) begin
      uv[i] = v[i-1];
      ud[i] = d[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RST_VAL;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= uv[i];
          // Bubbles leave data untouched; only a real item overwrites.
          if (uv[i]) begin
            d[i] <= ud[i];
          end
        end
      end
    end
  end

  // Popcount of the valid registers; depends on state only.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_c = cnt_c + CNT_W'(v[i]);
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = cnt_c;

endmodule

// File: tb/tb_dff_pipe_elastic.sv
// tb_dff_pipe_elastic: checks two configurations (DEPTH=3/WIDTH=8 and
// DEPTH=1/WIDTH=1) against an item-position model with a scoreboard.
module tb_dff_pipe_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // unit 0: DEPTH=3, WIDTH=8, RST_VAL=0x5A
  logic       rst0, flush0, iv0, ir0, ov0, or0;
  logic [7:0] id0, od0;
  logic [1:0] cnt0;

  // unit 1: DEPTH=1, WIDTH=1, RST_VAL=1
  logic rst1, flush1, iv1, ir1, ov1, or1;
  logic id1, od1;
  logic cnt1;

  dff_pipe_elastic #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) u0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .count(cnt0)
  );

  dff_pipe_elastic #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .count(cnt1)
  );

  int total = 0;
  int bad   = 0;

  // Model: ordered list of items in flight (oldest first), each with the
  // stage it occupies. Items slide toward the output as far as the item
  // ahead of them allows; the oldest item is also the scoreboard head.
  int         dep [2] = '{3, 1};
  logic [7:0] rv  [2] = '{8'h5A, 8'h01};
  int         n   [2] = '{0, 0};
  int         pos [2][4];
  logic [7:0] dat [2][4];
  logic [7:0] lastout [2];
  bit         armed [2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int u,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s u%0d t=%0t act=%0h exp=%0h", nm, u, $time, act, exp);
    end
  endtask

  task automatic unit(input int u, input bit r, input bit f, input bit iv,
                      input logic [7:0] id, input bit o,
                      input logic [31:0] a_ir, input logic [31:0] a_ov,
                      input logic [31:0] a_od, input logic [31:0] a_cnt);
    int  dd;
    int  lim;
    bit  eir;
    bit  eov;
    dd  = dep[u];
    eir = !f && (o || n[u] < dd);
    eov = n[u] > 0 && pos[u][0] == dd - 1;
    if (armed[u]) begin
      chk("in_ready", u, a_ir, 32'(eir));
      chk("out_valid", u, a_ov, 32'(eov));
      chk("count", u, a_cnt, 32'(n[u]));
      chk("out_data", u, a_od, 32'(lastout[u]));
    end
    if (r) begin
      n[u] = 0;
      lastout[u] = rv[u];
      armed[u] = 1'b1;
      return;
    end
    if (!armed[u]) return;
    // Scoreboard: consumer takes the head whenever the DUT offers data.
    if (a_ov === 32'd1 && o) begin
      if (n[u] == 0) begin
        chk("sb_empty", u, 32'd1, 32'd0);
      end else begin
        chk("sb_data", u, a_od, 32'(dat[u][0]));
      end
    end
    if (eov && o) begin
      for (int k = 1; k < n[u]; k++) begin
        pos[u][k-1] = pos[u][k];
        dat[u][k-1] = dat[u][k];
      end
      n[u]--;
    end
    if (f) begin
      n[u] = 0;
      return;
    end
    for (int k = 0; k < n[u]; k++) begin
      lim = (k == 0) ? dd - 1 : pos[u][k-1] - 1;
      pos[u][k] = (pos[u][k] + 1 < lim) ? pos[u][k] + 1 : lim;
    end
    if (iv && eir) begin
      pos[u][n[u]] = 0;
      dat[u][n[u]] = id;
      n[u]++;
    end
    if (n[u] > 0 && pos[u][0] == dd - 1) lastout[u] = dat[u][0];
  endtask

  always @(negedge clk) begin
    unit(0, rst0, flush0, iv0, id0, or0,
         {31'b0, ir0}, {31'b0, ov0}, {24'b0, od0}, {30'b0, cnt0});
    unit(1, rst1, flush1, iv1, {7'b0, id1}, or1,
         {31'b0, ir1}, {31'b0, ov1}, {31'b0, od1}, {31'b0, cnt1});
  end

  task automatic cyc0(input bit r, input bit f, input bit v,
                      input logic [7:0] d, input bit o);
    rst0 = r; flush0 = f; iv0 = v; id0 = d; or0 = o;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input bit r, input bit f, input bit v,
                      input logic d, input bit o);
    rst1 = r; flush1 = f; iv1 = v; id1 = d; or1 = o;
    @(posedge clk);
    #1;
  endtask

  task automatic stim0();
    cyc0(1, 0, 1, 8'hAA, 0);
    cyc0(1, 0, 1, 8'hAA, 0);
    // streaming
    for (int i = 1; i <= 10; i++) cyc0(0, 0, 1, 8'(i), 1);
    repeat (4) cyc0(0, 0, 0, 8'h00, 1);
    // backpressure fill
    cyc0(0, 0, 1, 8'h11, 0);
    cyc0(0, 0, 1, 8'h22, 0);
    cyc0(0, 0, 1, 8'h33, 0);
    cyc0(0, 0, 1, 8'h44, 0);
    cyc0(0, 0, 1, 8'h44, 1);
    repeat (4) cyc0(0, 0, 0, 8'h00, 1);
    // bubble collapse
    cyc0(0, 0, 1, 8'h01, 0);
    repeat (2) cyc0(0, 0, 0, 8'h00, 0);
    cyc0(0, 0, 1, 8'h02, 0);
    repeat (4) cyc0(0, 0, 0, 8'h00, 1);
    // flush with full pipe
    cyc0(0, 0, 1, 8'h0A, 0);
    cyc0(0, 0, 1, 8'h0B, 0);
    cyc0(0, 0, 1, 8'h0C, 0);
    cyc0(0, 1, 1, 8'h0D, 0);
    cyc0(0, 0, 1, 8'h0E, 1);
    repeat (4) cyc0(0, 0, 0, 8'h00, 1);
    // reset with two items in flight
    cyc0(0, 0, 1, 8'h71, 0);
    cyc0(0, 0, 1, 8'h72, 0);
    cyc0(1, 0, 1, 8'h73, 1);
    repeat (5) cyc0(0, 0, 1, 8'h80, 1);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc0($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
    end
    repeat (4) cyc0(0, 0, 0, 8'h00, 1);
  endtask

  task automatic stim1();
    cyc1(1, 0, 1, 1'b0, 0);
    cyc1(1, 0, 1, 1'b0, 0);
    cyc1(0, 0, 1, 1'b0, 0);
    cyc1(0, 0, 1, 1'b1, 0);
    cyc1(0, 0, 1, 1'b1, 1);
    cyc1(1, 0, 1, 1'b0, 1);
    for (int i = 0; i < 500; i++) begin
      cyc1($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 6);
    end
    repeat (3) cyc1(0, 0, 0, 1'b0, 1);
  endtask

  initial begin
    fork
      stim0();
      stim1();
    join
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_pipe_elastic.md
# dff_pipe_elastic

Parametrised elastic register pipeline: a DEPTH-stage chain of synchronous-reset data registers with per-stage valid bits and valid/ready backpressure. It is the general-purpose successor to the single-bit synchronous-reset flip-flop. Use it wherever a datapath needs fixed-latency retiming that can stall, collapse bubbles and be flushed. It sits between any producer and consumer that use valid/ready handshakes.

## Interface
Parameters:
- WIDTH, 8, data width in bits (>= 1)
- DEPTH, 3, number of register stages (>= 1)
- RST_VAL, 0, WIDTH-bit value loaded into every data register on rst
- CNT_W, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous clear of all valid bits
- in_valid  in  1  producer has data
- in_ready  out  1  pipeline accepts in_data this cycle
- in_data  in  WIDTH  input data
- out_valid  out  1  stage DEPTH-1 holds valid data
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  data of stage DEPTH-1
- count  out  CNT_W  number of stages currently holding valid data

## Operation
- Stages are indexed 0 (input side) to DEPTH-1 (output side). Each stage holds v[i] and d[i].
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[i] = !v[i] | r[i+1].
  - in_ready = r[0] & !flush.
- Upstream of stage i: for i=0 it is (in_valid & !flush, in_data); for i>0 it is (v[i-1], d[i-1]).
- Per-edge update, priority order:
  - rst: all v <= 0; all d <= RST_VAL.
  - else flush: all v <= 0; d unchanged.
  - else, for each stage with r[i]=1: v[i] <= upstream valid, and d[i] <= upstream data only when upstream valid=1. If upstream valid=0, d holds its value.
  - A stage with r[i]=0 holds both v and d.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Bubbles collapse: an empty stage always accepts, even when out_ready=0.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1], driven directly from registers.
- count = popcount(v), registered-equivalent and consistent with v after each edge. Range 0..DEPTH.
- Data order is strictly preserved. No duplication; no loss except by flush or rst.

## Timing
- Reset values: out_valid=0, out_data=RST_VAL, count=0. in_ready=1 after reset unless flush=1.
- Latency: an item accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles input to output, when unstalled.
- Throughput: 1 item/cycle sustained while out_ready=1.
- in_ready has a combinational path from out_ready through all DEPTH stages. This is intentional. No combinational path exists from in_valid or in_data to any output.
- Full (count=DEPTH) with out_ready=0: in_ready=0, all state holds.
- Full with out_ready=1: in_ready=1; input and output transfer on the same edge; count unchanged.
- Flush cycle:
  - in_ready=0, so no input is accepted.
  - If out_valid & out_ready, the item counts as consumed by the consumer.
  - All valids clear at the edge; count=0 next cycle.
- rst asserted mid-stream: all valids clear at that edge and data returns to RST_VAL, regardless of flush, in_valid or out_ready.
- DEPTH=1: single register with r[0] = !v[0] | out_ready. Same rules apply.

## Test plan
- Reset: drive in_valid=1, in_data=0xAA with rst=1 for 2 cycles, RST_VAL=0x5A -> out_valid=0, out_data=0x5A, count=0; in_ready=1 once rst=0 and flush=0.
- Streaming: DEPTH=3, out_ready=1, push 0x01..0x0A on consecutive cycles -> first out_valid 3 cycles after first accept; 0x01..0x0A emerge in order, one per cycle; count settles at 3.
- Backpressure fill: out_ready=0, push 0x11,0x22,0x33,0x44 -> first three accepted, in_ready=0 on the 4th, count=3, out_data=0x11. Then out_ready=1 for 1 cycle -> 0x11 consumed, 0x44 accepted the same cycle, count stays 3.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02, all with out_ready=0 -> both accepted, count=2, out_data=0x01. Releasing out_ready yields 0x01 then 0x02 on consecutive cycles.
- Flush: pipeline full (0xA,0xB,0xC), assert flush 1 cycle with in_valid=1, in_data=0xD -> in_ready=0 that cycle, count=0 next cycle, 0xD never appears at the output. Subsequent push 0xE emerges after DEPTH cycles.
- Mid-operation reset: stream with random out_ready, assert rst for 1 cycle while count=2 -> next cycle count=0, out_valid=0, out_data=RST_VAL. The post-reset stream is unaffected by earlier data. Repeat with DEPTH=1 and WIDTH=1.
